// File: rtl/floppy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : floppy_pkg
//  Description : Shared types, constants and helpers for the floppy drive
//                select / motor controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package floppy_pkg;

    localparam int NUM_DRIVES_MAX           = 4;
    localparam int DRIVE_IDX_W              = 2;
    localparam int TRACK_W                  = 7;
    localparam int MS_CNT_W                 = 12;
    localparam int MOTOR_TIMEOUT_MS_DEFAULT = 3000;

    typedef logic [DRIVE_IDX_W-1:0] drive_idx_t;
    typedef logic [TRACK_W-1:0]     track_t;

    // Index of the lowest set bit; callers guarantee at least one bit is set.
    function automatic drive_idx_t lowest_set(input logic [NUM_DRIVES_MAX-1:0] bits);
        drive_idx_t idx;
        idx = '0;
        for (int i = NUM_DRIVES_MAX - 1; i >= 0; i--) begin
            if (bits[i]) begin
                idx = drive_idx_t'(i);
            end
        end
        return idx;
    endfunction

    // One-hot decode of a drive index.
    function automatic logic [NUM_DRIVES_MAX-1:0] drive_onehot(input drive_idx_t idx);
        logic [NUM_DRIVES_MAX-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/floppy_motor_timer.sv
`default_nettype none
// ============================================================================
//  Module      : floppy_motor_timer
//  Description : Millisecond prescaler plus 12-bit ms down-counter that keeps
//                the drive motor running for a fixed time after the last
//                select write.
//  Revision    : 1.0 - initial release
// ============================================================================
module floppy_motor_timer
    import floppy_pkg::*;
#(
    parameter int CLKS_PER_MS = 42578,
    parameter int TIMEOUT_MS  = MOTOR_TIMEOUT_MS_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic clear,
    output logic active,
    output logic expire
);

    localparam int                    c_PRESC_W    = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [c_PRESC_W-1:0]  c_PRESC_LAST = c_PRESC_W'(CLKS_PER_MS - 1);
    localparam logic [MS_CNT_W-1:0]   c_TIMEOUT    = MS_CNT_W'(TIMEOUT_MS);

    logic                 r_active;
    logic [MS_CNT_W-1:0]  r_count;
    logic [c_PRESC_W-1:0] r_presc;
    logic                 w_tick;
    logic                 w_last;

    assign w_tick = r_active && (r_presc == c_PRESC_LAST);
    // A count of 1 becomes 0 on this tick; 0 covers a zero-length timeout.
    assign w_last = (r_count <= MS_CNT_W'(1));

    assign active = r_active;
    assign expire = w_tick && w_last;

    // Prescaler and ms counter; a load always beats a coincident expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= 1'b0;
            r_count  <= '0;
            r_presc  <= '0;
        end else if (load) begin
            r_active <= 1'b1;
            r_count  <= c_TIMEOUT;
            r_presc  <= '0;
        end else if (clear) begin
            r_active <= 1'b0;
            r_count  <= '0;
            r_presc  <= '0;
        end else if (r_active) begin
            if (w_tick) begin
                r_presc <= '0;
                if (w_last) begin
                    r_active <= 1'b0;
                    r_count  <= '0;
                end else begin
                    r_count <= r_count - MS_CNT_W'(1);
                end
            end else begin
                r_presc <= r_presc + c_PRESC_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/floppy_drive_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : floppy_drive_ctrl
//  Description : Drive-select latch, motor timeout and per-drive signal
//                routing between one FDC and up to four floppy instances.
//  Revision    : 1.0 - initial release
// ============================================================================
module floppy_drive_ctrl
    import floppy_pkg::*;
#(
    parameter int SYS_CLK          = 42578000,
    parameter int MOTOR_TIMEOUT_MS = MOTOR_TIMEOUT_MS_DEFAULT,
    parameter int NUM_DRIVES       = 4
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    sel_wr,
    input  logic [NUM_DRIVES_MAX-1:0]               sel_data,
    input  logic                                    step_in,
    input  logic                                    step_out,
    input  logic [NUM_DRIVES_MAX-1:0]               drive_present,
    input  logic [NUM_DRIVES_MAX-1:0]               drv_ready,
    input  logic [NUM_DRIVES_MAX-1:0]               drv_index,
    input  logic [NUM_DRIVES_MAX-1:0][TRACK_W-1:0]  drv_track,
    output logic [NUM_DRIVES_MAX-1:0]               drv_select,
    output logic [NUM_DRIVES_MAX-1:0]               drv_motor_on,
    output logic [NUM_DRIVES_MAX-1:0]               drv_step_in,
    output logic [NUM_DRIVES_MAX-1:0]               drv_step_out,
    output logic                                    ready,
    output logic                                    index,
    output logic [TRACK_W-1:0]                      track,
    output logic [DRIVE_IDX_W-1:0]                  cur_drive,
    output logic                                    motor_active
);

    localparam int                        c_CLKS_PER_MS = (SYS_CLK / 1000 > 0) ? SYS_CLK / 1000 : 1;
    // Select bits for drives that are not instantiated are ignored.
    localparam logic [NUM_DRIVES_MAX-1:0] c_SEL_MASK    = NUM_DRIVES_MAX'((1 << NUM_DRIVES) - 1);

    logic                      r_cur_valid;
    drive_idx_t                r_cur_drive;
    logic [NUM_DRIVES_MAX-1:0] r_drv_select;
    logic [NUM_DRIVES_MAX-1:0] r_drv_step_in;
    logic [NUM_DRIVES_MAX-1:0] r_drv_step_out;

    logic [NUM_DRIVES_MAX-1:0] w_sel_masked;
    logic                      w_sel_any;
    logic                      w_active;
    logic                      w_expire;
    logic                      w_valid_nxt;
    drive_idx_t                w_drive_nxt;
    logic [NUM_DRIVES_MAX-1:0] w_cur_onehot;

    assign w_sel_masked = sel_data & c_SEL_MASK;
    assign w_sel_any    = |w_sel_masked;
    assign w_cur_onehot = drive_onehot(r_cur_drive);

    floppy_motor_timer #(
        .CLKS_PER_MS (c_CLKS_PER_MS),
        .TIMEOUT_MS  (MOTOR_TIMEOUT_MS)
    ) u_motor_timer (
        .clk    (clk),
        .rst    (reset),
        .load   (sel_wr & w_sel_any),
        .clear  (sel_wr & ~w_sel_any),
        .active (w_active),
        .expire (w_expire)
    );

    // Next select-latch state: a write wins over a coincident expiry; the
    // drive index is kept on deselect so track stays meaningful.
    always_comb begin
        w_valid_nxt = r_cur_valid;
        w_drive_nxt = r_cur_drive;
        if (sel_wr) begin
            if (w_sel_any) begin
                w_valid_nxt = 1'b1;
                w_drive_nxt = lowest_set(w_sel_masked);
            end else begin
                w_valid_nxt = 1'b0;
            end
        end else if (w_expire) begin
            w_valid_nxt = 1'b0;
        end
    end

    // Select latch and registered per-drive outputs; steps route through the
    // pre-write latch so a select change hands the level over one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur_valid    <= 1'b0;
            r_cur_drive    <= '0;
            r_drv_select   <= '0;
            r_drv_step_in  <= '0;
            r_drv_step_out <= '0;
        end else begin
            r_cur_valid    <= w_valid_nxt;
            r_cur_drive    <= w_drive_nxt;
            r_drv_select   <= w_valid_nxt ? drive_onehot(w_drive_nxt) : '0;
            r_drv_step_in  <= (r_cur_valid && step_in)  ? w_cur_onehot : '0;
            r_drv_step_out <= (r_cur_valid && step_out) ? w_cur_onehot : '0;
        end
    end

    assign drv_select   = r_drv_select;
    assign drv_motor_on = r_drv_select;
    assign drv_step_in  = r_drv_step_in;
    assign drv_step_out = r_drv_step_out;
    assign cur_drive    = r_cur_drive;
    assign motor_active = w_active;

    assign ready = r_cur_valid & drive_present[r_cur_drive] & drv_ready[r_cur_drive];
    assign index = r_cur_valid & drv_index[r_cur_drive];
    assign track = drv_track[r_cur_drive];

endmodule
`default_nettype wire

// File: tb/tb_floppy_drive_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_floppy_drive_ctrl
//  Description : Self-checking bench for floppy_drive_ctrl. Two instances
//                (4 drives and 3 drives) share stimulus; a cycle-level model
//                of select, timeout and step routing predicts every output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_floppy_drive_ctrl;

    localparam int c_TIMEOUT_CYCLES = 12;  // 3 ms * 4 clk/ms

    logic             clk = 1'b0;
    logic             reset;
    logic             sel_wr;
    logic [3:0]       sel_data;
    logic             step_in;
    logic             step_out;
    logic [3:0]       drive_present;
    logic [3:0]       drv_ready;
    logic [3:0]       drv_index;
    logic [3:0][6:0]  drv_track;

    logic [3:0] o_select   [2];
    logic [3:0] o_motor_on [2];
    logic [3:0] o_step_in  [2];
    logic [3:0] o_step_out [2];
    logic       o_ready    [2];
    logic       o_index    [2];
    logic [6:0] o_track    [2];
    logic [1:0] o_cur      [2];
    logic       o_active   [2];

    int n_checks = 0;
    int n_errors = 0;

    // Model state per instance
    int         m_valid [2];
    int         m_drive [2];
    int         m_rem   [2];
    logic [3:0] m_sin   [2];
    logic [3:0] m_sout  [2];

    always #5 clk = ~clk;

    floppy_drive_ctrl #(.SYS_CLK(4000), .MOTOR_TIMEOUT_MS(3), .NUM_DRIVES(4)) u_dut4 (
        .clk(clk), .reset(reset), .sel_wr(sel_wr), .sel_data(sel_data),
        .step_in(step_in), .step_out(step_out), .drive_present(drive_present),
        .drv_ready(drv_ready), .drv_index(drv_index), .drv_track(drv_track),
        .drv_select(o_select[0]), .drv_motor_on(o_motor_on[0]),
        .drv_step_in(o_step_in[0]), .drv_step_out(o_step_out[0]),
        .ready(o_ready[0]), .index(o_index[0]), .track(o_track[0]),
        .cur_drive(o_cur[0]), .motor_active(o_active[0])
    );

    floppy_drive_ctrl #(.SYS_CLK(4000), .MOTOR_TIMEOUT_MS(3), .NUM_DRIVES(3)) u_dut3 (
        .clk(clk), .reset(reset), .sel_wr(sel_wr), .sel_data(sel_data),
        .step_in(step_in), .step_out(step_out), .drive_present(drive_present),
        .drv_ready(drv_ready), .drv_index(drv_index), .drv_track(drv_track),
        .drv_select(o_select[1]), .drv_motor_on(o_motor_on[1]),
        .drv_step_in(o_step_in[1]), .drv_step_out(o_step_out[1]),
        .ready(o_ready[1]), .index(o_index[1]), .track(o_track[1]),
        .cur_drive(o_cur[1]), .motor_active(o_active[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [3:0] d, input int nd);
        for (int b = 0; b < nd; b++) begin
            if (d[b]) return b;
        end
        return -1;
    endfunction

    // Advance the model by one clock edge using the inputs present at the edge.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            int nd;
            int l;
            nd = (i == 0) ? 4 : 3;
            if (reset) begin
                m_valid[i] = 0; m_drive[i] = 0; m_rem[i] = 0;
                m_sin[i] = 4'b0; m_sout[i] = 4'b0;
            end else begin
                m_sin[i]  = (m_valid[i] != 0 && step_in)  ? 4'(1 << m_drive[i]) : 4'b0;
                m_sout[i] = (m_valid[i] != 0 && step_out) ? 4'(1 << m_drive[i]) : 4'b0;
                if (sel_wr) begin
                    l = lowest(sel_data, nd);
                    if (l >= 0) begin
                        m_valid[i] = 1; m_drive[i] = l; m_rem[i] = c_TIMEOUT_CYCLES;
                    end else begin
                        m_valid[i] = 0; m_rem[i] = 0;
                    end
                end else if (m_valid[i] != 0) begin
                    m_rem[i]--;
                    if (m_rem[i] == 0) m_valid[i] = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            logic [3:0] sel;
            logic       v;
            v   = (m_valid[i] != 0);
            sel = v ? 4'(1 << m_drive[i]) : 4'b0;
            check($sformatf("i%0d.cur_drive", i), 32'(o_cur[i]), 32'(m_drive[i]));
            check($sformatf("i%0d.drv_select", i), 32'(o_select[i]), 32'(sel));
            check($sformatf("i%0d.drv_motor_on", i), 32'(o_motor_on[i]), 32'(sel));
            check($sformatf("i%0d.motor_active", i), 32'(o_active[i]), 32'(v));
            check($sformatf("i%0d.drv_step_in", i), 32'(o_step_in[i]), 32'(m_sin[i]));
            check($sformatf("i%0d.drv_step_out", i), 32'(o_step_out[i]), 32'(m_sout[i]));
            check($sformatf("i%0d.ready", i), 32'(o_ready[i]),
                  32'(v && drive_present[m_drive[i]] && drv_ready[m_drive[i]]));
            check($sformatf("i%0d.index", i), 32'(o_index[i]), 32'(v && drv_index[m_drive[i]]));
            check($sformatf("i%0d.track", i), 32'(o_track[i]), 32'(drv_track[m_drive[i]]));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_sel(input logic [3:0] d);
        sel_wr = 1'b1; sel_data = d;
        cycle();
        sel_wr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        reset = 1'b1; sel_wr = 1'b0; sel_data = 4'b0; step_in = 1'b0; step_out = 1'b0;
        drive_present = 4'hF; drv_ready = 4'hF; drv_index = 4'b0;
        for (int k = 0; k < 4; k++) drv_track[k] = 7'(10 * k + 3);
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 0; m_drive[i] = 0; m_rem[i] = 0; m_sin[i] = 4'b0; m_sout[i] = 4'b0;
        end
        idle(2);
        check("reset.select", 32'(o_select[0]), 32'h0);
        check("reset.active", 32'(o_active[0]), 32'h0);
        reset = 1'b0;
        idle(1);

        // Select drive 2, then let it time out after 12 cycles
        do_sel(4'b0100);
        check("sel2.cur_drive", 32'(o_cur[0]), 32'd2);
        check("sel2.select", 32'(o_select[0]), 32'h4);
        idle(11);
        check("sel2.still_on", 32'(o_motor_on[0]), 32'h4);
        idle(1);
        check("sel2.timeout", 32'(o_active[0]), 32'h0);

        // Lowest set bit wins; bit 3 alone is ignored on the 3-drive instance
        do_sel(4'b0110);
        check("lowest.cur_drive", 32'(o_cur[0]), 32'd1);
        do_sel(4'b1000);
        check("ignored.i4", 32'(o_select[0]), 32'h8);
        check("ignored.i3", 32'(o_select[1]), 32'h0);

        // Write coinciding with expiry reloads the timer
        do_sel(4'b0001);
        idle(11);
        do_sel(4'b0001);
        idle(11);
        check("reload.on", 32'(o_active[0]), 32'h1);
        idle(1);
        check("reload.off", 32'(o_active[0]), 32'h0);

        // Step routing, select handover while stepping, and deselect
        do_sel(4'b0001);
        step_in = 1'b1; cycle(); step_in = 1'b0;
        check("step.d0", 32'(o_step_in[0]), 32'h1);
        step_out = 1'b1; cycle();
        do_sel(4'b0010);
        check("step.handover_old", 32'(o_step_out[0]), 32'h1);
        cycle();
        check("step.handover_new", 32'(o_step_out[0]), 32'h2);
        step_out = 1'b0;
        do_sel(4'b0000);
        step_in = 1'b1; cycle(); cycle(); step_in = 1'b0;
        check("step.deselected", 32'(o_step_in[0]), 32'h0);

        // Ready gating by drive_present
        drive_present = 4'b0111; drv_ready = 4'hF;
        do_sel(4'b1000);
        check("ready.absent", 32'(o_ready[0]), 32'h0);
        do_sel(4'b0010);
        check("ready.present", 32'(o_ready[0]), 32'h1);
        check("track.d1", 32'(o_track[0]), 32'd13);

        // Reset mid-timeout with a concurrent write
        idle(3);
        reset = 1'b1; sel_wr = 1'b1; sel_data = 4'b0100;
        cycle();
        reset = 1'b0; sel_wr = 1'b0;
        check("rst.select", 32'(o_select[0]), 32'h0);
        idle(5);
        check("rst.idle", 32'(o_active[0]), 32'h0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset    = ($urandom_range(0, 299) == 0);
            sel_wr   = ($urandom_range(0, 9) == 0);
            sel_data = 4'($urandom);
            if ($urandom_range(0, 3) == 0) step_in  = ~step_in;
            if ($urandom_range(0, 3) == 0) step_out = ~step_out;
            if ($urandom_range(0, 15) == 0) begin
                drive_present = 4'($urandom);
                drv_ready     = 4'($urandom);
                for (int k = 0; k < 4; k++) drv_track[k] = 7'($urandom_range(0, 79));
            end
            drv_index = 4'($urandom);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/floppy_drive_ctrl.md
FLOPPY_DRIVE_CTRL -- requirements
Module: floppy_drive_ctrl

Interface
REQ-001 The block SHALL have parameter SYS_CLK, default 42578000: system clock rate in Hz.
REQ-002 The block SHALL have parameter MOTOR_TIMEOUT_MS, default 3000: motor run time after the last select write, in ms.
REQ-003 The block SHALL have parameter NUM_DRIVES, default 4: number of floppy instances served.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock. The block uses one clock.
REQ-005 The block SHALL have port reset, input, 1 bit: reset. Reset is synchronous and active-high.
REQ-006 The block SHALL have port sel_wr, input, 1 bit: one-cycle strobe for a CPU write to the drive-select latch.
REQ-007 The block SHALL have port sel_data, input, 4 bits: one-hot drive-select bits from the CPU.
REQ-008 The block SHALL have port step_in, input, 1 bit: FDC step-in level.
REQ-009 The block SHALL have port step_out, input, 1 bit: FDC step-out level.
REQ-010 The block SHALL have port drive_present, input, 4 bits: disk image mounted, one bit per drive.
REQ-011 The block SHALL have port drv_ready, input, 4 bits: per-drive ready.
REQ-012 The block SHALL have port drv_index, input, 4 bits: per-drive index.
REQ-013 The block SHALL have port drv_track, input, 4x7 bits: per-drive current track.
REQ-014 The block SHALL have port drv_select, output, 4 bits: per-drive select.
REQ-015 The block SHALL have port drv_motor_on, output, 4 bits: per-drive motor_on.
REQ-016 The block SHALL have port drv_step_in, output, 4 bits: per-drive step_in.
REQ-017 The block SHALL have port drv_step_out, output, 4 bits: per-drive step_out.
REQ-018 The block SHALL have port ready, output, 1 bit: ready of the selected drive, for the FDC.
REQ-019 The block SHALL have port index, output, 1 bit: index of the selected drive.
REQ-020 The block SHALL have port track, output, 7 bits: track of the selected drive.
REQ-021 The block SHALL have port cur_drive, output, 2 bits: index of the selected drive.
REQ-022 The block SHALL have port motor_active, output, 1 bit: high while the motor timer is running.

Function
REQ-023 On sel_wr with sel_data != 0, the block SHALL latch cur_drive as the index of the lowest set bit, set cur_valid, and reload the motor timer to MOTOR_TIMEOUT_MS. The prescaler SHALL also restart.
REQ-024 On sel_wr with sel_data == 0, the block SHALL clear cur_valid and stop the timer in the next cycle.
REQ-025 The prescaler SHALL produce a 1 ms tick every SYS_CLK/1000 clocks while motor_active is high. The ms counter SHALL be 12 bits and decrement on each tick.
REQ-026 When the ms counter reaches 0 on a tick, the block SHALL clear motor_active and cur_valid in the same cycle.
REQ-027 If sel_wr coincides with an expiring tick, the write SHALL win: the timer reloads and the drive stays selected.
REQ-028 drv_select[cur_drive] and drv_motor_on[cur_drive] SHALL be 1 only while cur_valid is high. All other bits SHALL be 0. These outputs SHALL be registered with 1-cycle latency after sel_wr.
REQ-029 step_in and step_out SHALL be registered into drv_step_in and drv_step_out of the currently latched drive (1-cycle latency). They SHALL be dropped (all 0) when cur_valid is low.
REQ-030 A step sampled in the same cycle as sel_wr SHALL route using the latch value before the write.
REQ-031 A select change while a step level is high SHALL deassert the step on the old drive. The new drive SHALL receive the level on the next cycle and see a rising edge.
REQ-032 ready SHALL equal cur_valid & drive_present[cur_drive] & drv_ready[cur_drive], and SHALL be combinational from registered state.
REQ-033 index SHALL equal drv_index[cur_drive] when cur_valid is high, else 0.
REQ-034 track SHALL equal drv_track[cur_drive] and SHALL remain valid after deselect.
REQ-035 Selecting a drive whose drive_present bit is 0 SHALL still assert select and motor_on, with ready held 0.
REQ-036 For NUM_DRIVES < 4, sel_data bits >= NUM_DRIVES SHALL be ignored. A write containing only ignored bits SHALL act as sel_data == 0.

Reset
REQ-037 Reset SHALL clear cur_valid, cur_drive, motor_active, the ms counter and the prescaler, and all registered outputs to 0.
REQ-038 Reset asserted mid-timeout SHALL stop the motor the next cycle. A concurrent sel_wr during reset SHALL be ignored.

Structure
REQ-039 Package floppy_pkg SHALL hold NUM_DRIVES_MAX=4, the drive index type (2 bits), the track type (7 bits) and the MOTOR_TIMEOUT_MS default.
REQ-040 One sub-module, floppy_motor_timer, SHALL implement the prescaler and ms counter with ports load, clear, active and expire.
REQ-041 Muxes and routing SHALL stay in the top module.

Verification (SYS_CLK=4000, MOTOR_TIMEOUT_MS=3, so 1 ms = 4 clk)
REQ-042 sel_wr with sel_data=4'b0100 -> the next cycle has cur_drive=2, drv_select=4'b0100 and drv_motor_on=4'b0100; 12 cycles later all are 0 and motor_active=0.
REQ-043 sel_data=4'b0110 -> cur_drive=1 (lowest bit wins).
REQ-044 sel_wr at count 1 coinciding with expire -> the timer reloads and the motor stays on for another 12 cycles.
REQ-045 With drive 0 selected, a step_in pulse -> drv_step_in=4'b0001 one cycle later. After a zero write, a step_in pulse -> drv_step_in stays 0.
REQ-046 Select drive 3 with drive_present=4'b0111 and drv_ready=4'hF -> ready=0. Select drive 1 -> ready=1, and track equals drv_track[1].
REQ-047 Reset asserted mid-timeout together with sel_wr -> all outputs 0 the next cycle, and the timer stays idle.
